// File: rtl/fft16_pkg.sv
// Shared types and helpers for the 16-point FFT sequencer: state encoding,
// transform size constants and the load-address bit reversal.
package fft16_pkg;

  localparam int unsigned FFT_LOG2N = 4;
  localparam int unsigned FFT_N     = 1 << FFT_LOG2N;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_DRAIN,
    ST_UNLOAD,
    ST_DONE
  } state_e;

  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] x);
    logic [FFT_LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FFT_LOG2N; i++) begin
      r[i] = x[FFT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft16_bf_addr_gen.sv
// Radix-2 DIT butterfly address generator: maps (stage, butterfly index) to the
// top/bottom operand addresses and the twiddle ROM index. Purely combinational.
module fft16_bf_addr_gen #(
  parameter int unsigned LOG2N = 4
) (
  input  logic [1:0]       stage_i,
  input  logic [LOG2N-2:0] bf_i,
  output logic [LOG2N-1:0] a_o,
  output logic [LOG2N-1:0] b_o,
  output logic [LOG2N-2:0] tw_o
);

  logic [LOG2N-1:0] bfx;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;
  logic [LOG2N-1:0] tw_full;
  logic [2:0]       sh_grp;
  logic [2:0]       sh_tw;

  always_comb begin
    bfx     = {1'b0, bf_i};
    half    = LOG2N'(1) << stage_i;
    pos     = bfx & (half - LOG2N'(1));
    grp     = bfx >> stage_i;
    sh_grp  = {1'b0, stage_i} + 3'd1;
    sh_tw   = 3'(LOG2N - 1) - {1'b0, stage_i};
    a_o     = (grp << sh_grp) | pos;
    b_o     = a_o + half;
    tw_full = pos << sh_tw;
    tw_o    = tw_full[LOG2N-2:0];
  end

endmodule

// File: rtl/fft16_sequencer.sv
// Control FSM for the 16-point radix-2 DIT FFT: bit-reversed load, 4x8 paced
// butterfly issues with a drain gap per stage, then natural-order unload.
module fft16_sequencer
  import fft16_pkg::*;
#(
  parameter int unsigned LOG2N      = FFT_LOG2N,
  parameter int unsigned BF_LATENCY = 3,
  parameter int unsigned DIV_LOG2   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_ld_we,
  output logic [LOG2N-1:0] o_ld_addr,
  output logic             o_bf_issue,
  output logic [LOG2N-1:0] o_bf_addr_a,
  output logic [LOG2N-1:0] o_bf_addr_b,
  output logic [LOG2N-2:0] o_bf_tw_idx,
  output logic [1:0]       o_bf_stage,
  output logic             o_rd_en,
  output logic [LOG2N-1:0] o_rd_addr,
  output logic             o_out_last,
  input  logic             i_out_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned PW = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;
  localparam logic [PW-1:0] PMAX = PW'((1 << DIV_LOG2) - 1);
  localparam int unsigned DW = $clog2(BF_LATENCY + 1);
  localparam logic [DW-1:0] DLAST = DW'(BF_LATENCY - 1);
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(FFT_N - 1);
  localparam logic [LOG2N-2:0] BF_LAST = '1;
  localparam logic [1:0] S_LAST = 2'(LOG2N - 1);

  state_e           state_q, state_d;
  logic [LOG2N-1:0] n_q, n_d;
  logic [LOG2N-2:0] bf_q, bf_d;
  logic [1:0]       s_q, s_d;
  logic [LOG2N-1:0] m_q, m_d;
  logic [DW-1:0]    dr_q, dr_d;
  logic [PW-1:0]    pr_q, pr_d;

  logic             issue_q, issue_d;
  logic [LOG2N-1:0] addr_a_q, addr_b_q;
  logic [LOG2N-2:0] tw_q;
  logic [1:0]       stage_q;

  logic [LOG2N-1:0] gen_a, gen_b;
  logic [LOG2N-2:0] gen_tw;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    bf_d    = bf_q;
    s_d     = s_q;
    m_d     = m_q;
    dr_d    = dr_q;
    pr_d    = pr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          n_d     = '0;
        end
      end
      ST_LOAD: begin
        if (i_in_valid) begin
          n_d = n_q + LOG2N'(1);
          if (n_q == CNT_LAST) begin
            state_d = ST_CALC;
            s_d     = '0;
            bf_d    = '0;
            pr_d    = '0;
          end
        end
      end
      ST_CALC: begin
        pr_d = (pr_q == PMAX) ? '0 : pr_q + PW'(1);
        if (pr_q == '0) begin
          if (bf_q == BF_LAST) begin
            state_d = ST_DRAIN;
            dr_d    = '0;
          end else begin
            bf_d = bf_q + (LOG2N-1)'(1);
          end
        end
      end
      ST_DRAIN: begin
        dr_d = dr_q + DW'(1);
        if (dr_q == DLAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_UNLOAD;
            m_d     = '0;
          end else begin
            state_d = ST_CALC;
            s_d     = s_q + 2'd1;
            bf_d    = '0;
            pr_d    = '0;
          end
        end
      end
      ST_UNLOAD: begin
        if (i_out_ready) begin
          m_d = m_q + LOG2N'(1);
          if (m_q == CNT_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue is decided one cycle early from next-state values so the registered
  // op lands on the very cycle CALC is entered.
  assign issue_d = (state_d == ST_CALC) && (pr_d == '0);

  fft16_bf_addr_gen #(
    .LOG2N(LOG2N)
  ) u_addr_gen (
    .stage_i(s_d),
    .bf_i   (bf_d),
    .a_o    (gen_a),
    .b_o    (gen_b),
    .tw_o   (gen_tw)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      bf_q     <= '0;
      s_q      <= '0;
      m_q      <= '0;
      dr_q     <= '0;
      pr_q     <= '0;
      issue_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
      stage_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      bf_q    <= bf_d;
      s_q     <= s_d;
      m_q     <= m_d;
      dr_q    <= dr_d;
      pr_q    <= pr_d;
      issue_q <= issue_d;
      if (issue_d) begin
        addr_a_q <= gen_a;
        addr_b_q <= gen_b;
        tw_q     <= gen_tw;
        stage_q  <= s_d;
      end
    end
  end

  assign o_in_ready  = (state_q == ST_LOAD);
  assign o_ld_we     = o_in_ready & i_in_valid;
  assign o_ld_addr   = bitrev(n_q);
  assign o_bf_issue  = issue_q;
  assign o_bf_addr_a = addr_a_q;
  assign o_bf_addr_b = addr_b_q;
  assign o_bf_tw_idx = tw_q;
  assign o_bf_stage  = stage_q;
  assign o_rd_en     = (state_q == ST_UNLOAD);
  assign o_rd_addr   = m_q;
  assign o_out_last  = o_rd_en && (m_q == CNT_LAST);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);

endmodule
